// File: rtl/map_cfg_loader.sv
// Mapper configuration loader: receives a checksummed frame from the MCU byte link
// and commits it atomically while the console CPU is held in reset, then pulses map_rst.
// Optional build macro MAP_CFG_TIMEOUT_EN adds an inter-byte timeout in DATA/CSUM.
module map_cfg_loader #(
  parameter int          CFG_BYTES   = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          RST_HOLD    = 16,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_dat,
  input  logic                   rx_we,
  output logic                   rx_rdy,
  input  logic                   cpu_rst,
  output logic [7:0]             map_idx,
  output logic [3:0]             map_sub,
  output logic [CFG_BYTES*8-1:0] cfg_dat,
  output logic                   cfg_ok,
  output logic                   map_rst,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int IW = $clog2(CFG_BYTES);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  generate
    if (CFG_BYTES < 2 || RST_HOLD < 1 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("map_cfg_loader: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CSUM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             acc_reg;
  logic [IW-1:0]          idx_reg;
  logic [HW-1:0]          hold_reg;
  logic [7:0]             shadow_reg [CFG_BYTES];
  logic [CFG_BYTES*8-1:0] shadow_flat;

  logic accept;
  logic last_data;
  logic csum_bad;
  logic commit;
  logic timeout;

  assign accept    = rx_we & rx_rdy;
  assign last_data = (idx_reg == IW'(CFG_BYTES - 1));
  assign csum_bad  = (state_reg == S_CSUM) && accept && (rx_dat != acc_reg);
  assign commit    = (state_reg == S_WAIT) && cpu_rst;

`ifdef MAP_CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_reg;
  logic          in_frame;

  assign in_frame = (state_reg == S_DATA) || (state_reg == S_CSUM);
  assign timeout  = in_frame && !accept && (to_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || accept) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Shadow bytes are written by position so the commit can copy them all in one edge.
  generate
    for (genvar gi = 0; gi < CFG_BYTES; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= 8'h00;
        end else if ((state_reg == S_DATA) && accept && (idx_reg == IW'(gi))) begin
          shadow_reg[gi] <= rx_dat;
        end
      end
      assign shadow_flat[gi*8 +: 8] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rx_rdy     = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        rx_rdy = 1'b1;
        busy   = 1'b0;
        if (accept && (rx_dat == HDR_BYTE)) state_next = S_DATA;
      end
      S_DATA: begin
        rx_rdy = 1'b1;
        if (timeout)                  state_next = S_IDLE;
        else if (accept && last_data) state_next = S_CSUM;
      end
      S_CSUM: begin
        rx_rdy = 1'b1;
        if (timeout)     state_next = S_IDLE;
        else if (accept) state_next = (rx_dat == acc_reg) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (cpu_rst) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (hold_reg == '0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg  <= 8'h00;
      idx_reg  <= '0;
      hold_reg <= '0;
      map_idx  <= 8'h00;
      map_sub  <= 4'h0;
      cfg_dat  <= '0;
      cfg_ok   <= 1'b0;
      map_rst  <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      if ((state_reg == S_IDLE) && accept && (rx_dat == HDR_BYTE)) begin
        acc_reg <= HDR_BYTE;
        idx_reg <= '0;
      end else if ((state_reg == S_DATA) && accept) begin
        acc_reg <= acc_reg ^ rx_dat;
        idx_reg <= idx_reg + IW'(1);
      end

      if ((csum_bad || timeout) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'h01;
      end

      // All live fields move together on the commit edge.
      if (commit) begin
        cfg_dat  <= shadow_flat;
        map_idx  <= shadow_reg[0];
        map_sub  <= shadow_reg[1][3:0];
        cfg_ok   <= 1'b1;
        map_rst  <= 1'b1;
        hold_reg <= HW'(RST_HOLD - 1);
      end else if (state_reg == S_HOLD) begin
        if (hold_reg == '0) map_rst  <= 1'b0;
        else                hold_reg <= hold_reg - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_map_cfg_loader.sv
// Self-checking bench for map_cfg_loader: directed frames plus randomized frames
// compared against a frame-level model (checksum = header XOR all data bytes).
module tb_map_cfg_loader;

  localparam int         CB  = 8;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         RH  = 16;
  localparam int         TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_dat = 8'h00;
  logic          rx_we = 1'b0;
  logic          rx_rdy;
  logic          cpu_rst = 1'b1;
  logic [7:0]    map_idx;
  logic [3:0]    map_sub;
  logic [CB*8-1:0] cfg_dat;
  logic          cfg_ok;
  logic          map_rst;
  logic          busy;
  logic [7:0]    err_cnt;

  map_cfg_loader #(
    .CFG_BYTES  (CB),
    .HDR_BYTE   (HDR),
    .RST_HOLD   (RH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_dat (rx_dat),
    .rx_we  (rx_we),
    .rx_rdy (rx_rdy),
    .cpu_rst(cpu_rst),
    .map_idx(map_idx),
    .map_sub(map_sub),
    .cfg_dat(cfg_dat),
    .cfg_ok (cfg_ok),
    .map_rst(map_rst),
    .busy   (busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what the live outputs should currently show.
  logic [CB*8-1:0] exp_cfg;
  logic            exp_ok;
  int              exp_err;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_map_idx"}, 64'(map_idx), 64'(exp_cfg[7:0]));
    chk({tag, "_map_sub"}, 64'(map_sub), 64'(exp_cfg[11:8]));
    chk({tag, "_cfg_dat"}, 64'(cfg_dat), 64'(exp_cfg));
    chk({tag, "_cfg_ok"},  64'(cfg_ok),  64'(exp_ok));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  task automatic model_reset();
    exp_cfg = '0;
    exp_ok  = 1'b0;
    exp_err = 0;
  endtask

  task automatic model_reject();
    if (exp_err < 255) exp_err++;
  endtask

  function automatic logic [7:0] calc_csum(input logic [CB*8-1:0] d);
    logic [7:0] c = HDR;
    for (int i = 0; i < CB; i++) c ^= d[i*8 +: 8];
    return c;
  endfunction

  // Called at a negedge; the byte is taken on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_dat = b;
    rx_we  = 1'b1;
    @(negedge clk);
    rx_we  = 1'b0;
  endtask

  task automatic send_frame(input logic [CB*8-1:0] d, input logic [7:0] cs);
    send_byte(HDR);
    for (int i = 0; i < CB; i++) send_byte(d[i*8 +: 8]);
    send_byte(cs);
  endtask

  task automatic send_noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == HDR) b = 8'h00;
      send_byte(b);
    end
  endtask

  // Entered one cycle after the checksum byte; cpu_rst must be high by now.
  task automatic finish_commit(input string tag, input logic [CB*8-1:0] d, input bit drop_cpu);
    int n;
    chk({tag, "_wait_map_rst"}, 64'(map_rst), 64'd0);
    chk({tag, "_wait_rx_rdy"},  64'(rx_rdy),  64'd0);
    chk({tag, "_wait_busy"},    64'(busy),    64'd1);
    @(negedge clk);
    exp_cfg = d;
    exp_ok  = 1'b1;
    chk({tag, "_commit_map_rst"}, 64'(map_rst), 64'd1);
    check_live({tag, "_commit"});
    n = 0;
    while (map_rst === 1'b1 && n < 100) begin
      n++;
      if (drop_cpu && n == 3) cpu_rst = 1'b0;
      @(negedge clk);
    end
    cpu_rst = 1'b1;
    chk({tag, "_hold_len"}, 64'(n), 64'(RH));
    chk({tag, "_idle_busy"},   64'(busy),   64'd0);
    chk({tag, "_idle_rx_rdy"}, 64'(rx_rdy), 64'd1);
  endtask

  task automatic good_frame(input string tag, input logic [CB*8-1:0] d);
    send_frame(d, calc_csum(d));
    finish_commit(tag, d, 1'b0);
  endtask

  task automatic bad_frame(input string tag, input logic [CB*8-1:0] d);
    logic seen;
    send_frame(d, calc_csum(d) ^ 8'($urandom_range(1, 255)));
    model_reject();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= map_rst;
      @(negedge clk);
    end
    chk({tag, "_no_map_rst"}, 64'(seen), 64'd0);
    chk({tag, "_busy"},       64'(busy), 64'd0);
    check_live(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CB*8-1:0] d;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_live("reset");
    chk("reset_map_rst", 64'(map_rst), 64'd0);
    chk("reset_rx_rdy",  64'(rx_rdy),  64'd1);
    chk("reset_busy",    64'(busy),    64'd0);

    // Bad checksum first, then the same frame with the right checksum
    d = 64'h0000_0000_0000_0304;
    send_frame(d, 8'hA3);
    model_reject();
    chk("badcs_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("badcs_map_rst", 64'(map_rst), 64'd0);
    check_live("badcs");
    send_frame(d, 8'hA2);
    finish_commit("good1", d, 1'b0);

    // Deferred commit: cpu_rst low; bytes during WAIT are lost; cpu_rst dropped mid-hold
    cpu_rst = 1'b0;
    d = 64'h1122_3344_5566_0709;
    send_frame(d, calc_csum(d));
    chk("defer_busy",   64'(busy),   64'd1);
    chk("defer_rx_rdy", 64'(rx_rdy), 64'd0);
    send_byte(HDR);
    repeat (49) @(negedge clk);
    chk("defer_map_rst", 64'(map_rst), 64'd0);
    check_live("defer_old");
    cpu_rst = 1'b1;
    finish_commit("defer", d, 1'b1);

    // Framing: noise before header, header value embedded as data byte 2
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    d = 64'h0807_0605_04A5_0E31;
    good_frame("framing", d);

    // Randomized frames against the model
    for (int t = 0; t < 40; t++) begin
      send_noise($urandom_range(0, 3));
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bad_frame($sformatf("rand%0d_bad", t), d);
      else                           good_frame($sformatf("rand%0d_good", t), d);
    end

    // rst during DATA after four bytes
    send_byte(HDR);
    send_byte(8'h44);
    send_byte(8'h05);
    send_byte(8'h66);
    chk("rstdata_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_live("rstdata");
    chk("rstdata_busy",   64'(busy),   64'd0);
    chk("rstdata_rx_rdy", 64'(rx_rdy), 64'd1);
    rst = 1'b0;
    good_frame("after_rstdata", 64'h0102_0304_0506_0B2C);

    // rst during HOLD
    d = 64'hDEAD_BEEF_0000_0F77;
    send_frame(d, calc_csum(d));
    repeat (4) @(negedge clk);
    chk("rsthold_map_rst_before", 64'(map_rst), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rsthold_map_rst", 64'(map_rst), 64'd0);
    chk("rsthold_busy",    64'(busy),    64'd0);
    check_live("rsthold");
    rst = 1'b0;
    good_frame("after_rsthold", 64'hCAFE_F00D_1234_0A21);

    // Inter-byte stall of TO+1 cycles after byte 3
    d = 64'h5A5B_5C5D_5E5F_0613;
    send_byte(HDR);
    for (int i = 0; i < 3; i++) send_byte(d[i*8 +: 8]);
    repeat (TO + 1) @(negedge clk);
`ifdef MAP_CFG_TIMEOUT_EN
    model_reject();
    chk("stall_busy", 64'(busy), 64'd0);
    check_live("stall_abandon");
`else
    chk("stall_busy", 64'(busy), 64'd1);
    for (int i = 3; i < CB; i++) send_byte(d[i*8 +: 8]);
    send_byte(calc_csum(d));
    finish_commit("stall", d, 1'b0);
`endif

    // err_cnt saturation
    for (int t = 0; t < 256; t++) begin
      d = {$urandom, $urandom};
      send_frame(d, calc_csum(d) ^ 8'h5A);
      model_reject();
    end
    chk("sat_err_cnt", 64'(err_cnt), 64'd255);
    check_live("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
